// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request/response and data-memory pins of the LSU
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;
  logic        sb_empty;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, mem_access_addr, mem_write_data,
           mem_write_en, mem_read, sb_empty
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, mem_access_addr, mem_write_data,
           mem_write_en, mem_read, sb_empty
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: posted store buffer with youngest-match load forwarding, drained on idle port cycles
module load_store_unit #(
  parameter int SB_DEPTH        = 4,
  parameter int ADDR_MATCH_BITS = 3
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus_io
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   load_addr_q, load_addr_d, rdata_q, rdata_d;
  logic [15:0]   sb_addr_q [SB_DEPTH];
  logic [15:0]   sb_data_q [SB_DEPTH];
  logic          full, accept, push, pop, hit;
  logic [15:0]   fwd;
  assign full             = count_q == CW'(SB_DEPTH);
  assign bus_io.req_ready = (state_q == IDLE) && !full && !rst;
  assign accept           = bus_io.req_valid && bus_io.req_ready;
  assign push             = accept && bus_io.req_write;
  assign pop              = (state_q != LOAD) && !accept && (count_q != '0);
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < SB_DEPTH; k++)
      if (CW'(k) < count_q &&
          sb_addr_q[head_q + PW'(k)][ADDR_MATCH_BITS-1:0] == load_addr_q[ADDR_MATCH_BITS-1:0]) begin
        hit = 1'b1;
        fwd = sb_data_q[head_q + PW'(k)];
      end
  end
  always_comb begin
    state_d                = state_q == LOAD ? RESP :
                             state_q == RESP ? IDLE :
                             (accept && !bus_io.req_write) ? LOAD : IDLE;
    load_addr_d            = (accept && !bus_io.req_write) ? bus_io.req_addr : load_addr_q;
    rdata_d                = state_q == LOAD ? (hit ? fwd : bus_io.mem_read_data) : rdata_q;
    head_d                 = pop ? head_q + PW'(1) : head_q;
    tail_d                 = push ? tail_q + PW'(1) : tail_q;
    count_d                = count_q + CW'(push) - CW'(pop);
    bus_io.mem_read        = (state_q == LOAD) && !hit;
    bus_io.mem_write_en    = pop;
    bus_io.mem_access_addr = bus_io.mem_read ? load_addr_q : pop ? sb_addr_q[head_q] : '0;
    bus_io.mem_write_data  = pop ? sb_data_q[head_q] : '0;
    bus_io.resp_valid      = state_q == RESP;
    bus_io.resp_rdata      = rdata_q;
    bus_io.sb_empty        = count_q == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      load_addr_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      load_addr_q <= load_addr_d;
      rdata_q     <= rdata_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      sb_addr_q[tail_q] <= bus_io.req_addr;
      sb_data_q[tail_q] <= bus_io.req_wdata;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random traffic against a committed-memory plus pending-store model
module tb_load_store_unit;
  typedef struct packed {logic [15:0] a; logic [15:0] d;} st_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] mem     [8];
  logic [15:0] ref_mem [8];
  st_t         pend [$];
  int          tests = 0;
  int          fails = 0;
  int          due   = 0;
  logic [15:0] exp_data = '0;
  load_store_unit_if bus();
  load_store_unit #(.SB_DEPTH(4), .ADDR_MATCH_BITS(3)) dut (.clk(clk), .rst(rst), .bus_io(bus.slave));
  always #5 clk = ~clk;
  assign bus.mem_read_data = mem[bus.mem_access_addr[2:0]];
  always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // A load sees committed memory overlaid by every pending store, youngest last.
  function automatic logic [15:0] model_load(input logic [15:0] a);
    logic [15:0] v;
    v = ref_mem[a[2:0]];
    foreach (pend[i]) if (pend[i].a[2:0] == a[2:0]) v = pend[i].d;
    return v;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      due = 0;
    end else begin
      chk("sb_empty", bus.sb_empty, pend.size() == 0);
      chk("req_ready", bus.req_ready, due == 0 && pend.size() < 4);
      chk("port_excl", bus.mem_write_en & bus.mem_read, 0);
      if (!bus.mem_write_en && !bus.mem_read)
        chk("idle_bus", {bus.mem_access_addr, bus.mem_write_data}, 0);
      if (bus.mem_write_en && pend.size() == 0) chk("spurious_write", bus.mem_write_en, 0);
      if (bus.mem_write_en && pend.size() != 0) begin
        chk("wr_addr", bus.mem_access_addr, pend[0].a);
        chk("wr_data", bus.mem_write_data, pend[0].d);
        ref_mem[pend[0].a[2:0]] = pend[0].d;
        void'(pend.pop_front());
      end
      chk("resp_valid", bus.resp_valid, due == 1);
      if (due == 1) chk("resp_rdata", bus.resp_rdata, exp_data);
      if (due > 0) due--;
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_write) pend.push_back(st_t'{bus.req_addr, bus.req_wdata});
        else begin
          exp_data = model_load(bus.req_addr);
          due = 2;
        end
      end
    end
  end
  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (!bus.req_ready) chk("accept_timeout", bus.req_ready, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    mem[2] = 16'h1234;
    mem[4] = 16'h0F0F;
    for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_sb_empty", bus.sb_empty, 1);
    chk("rst_mem_pins", {bus.mem_write_en, bus.mem_read, bus.mem_access_addr, bus.mem_write_data}, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    req(1'b0, 16'h0002, 16'h0);
    chk("t1_mem_read", bus.mem_read, 1);
    chk("t1_addr", bus.mem_access_addr, 16'h0002);
    chk("t1_resp_early", bus.resp_valid, 0);
    idle(1);
    chk("t1_resp_valid", bus.resp_valid, 1);
    chk("t1_rdata", bus.resp_rdata, 16'h1234);
    idle(1);
    chk("t1_one_pulse", bus.resp_valid, 0);
    req(1'b1, 16'h0005, 16'hAAAA);
    req(1'b1, 16'h0006, 16'hBBBB);
    req(1'b1, 16'h0007, 16'hCCCC);
    req(1'b1, 16'h0000, 16'hDDDD);
    chk("t2_full_ready", bus.req_ready, 0);
    chk("t2_we0", bus.mem_write_en, 1);
    chk("t2_addr0", {bus.mem_access_addr, bus.mem_write_data}, {16'h0005, 16'hAAAA});
    idle(1);
    chk("t2_ready_back", bus.req_ready, 1);
    chk("t2_addr1", {bus.mem_access_addr, bus.mem_write_data}, {16'h0006, 16'hBBBB});
    idle(1);
    chk("t2_addr2", {bus.mem_access_addr, bus.mem_write_data}, {16'h0007, 16'hCCCC});
    idle(1);
    chk("t2_addr3", {bus.mem_access_addr, bus.mem_write_data}, {16'h0000, 16'hDDDD});
    idle(1);
    chk("t2_empty", bus.sb_empty, 1);
    chk("t2_we_off", bus.mem_write_en, 0);
    req(1'b1, 16'h0003, 16'h1111);
    req(1'b1, 16'h000B, 16'h2222);
    req(1'b0, 16'h0003, 16'h0);
    chk("t3_no_read", bus.mem_read, 0);
    chk("t3_no_write", bus.mem_write_en, 0);
    idle(1);
    chk("t3_rdata", bus.resp_rdata, 16'h2222);
    idle(6);
    req(1'b1, 16'h0001, 16'h5555);
    req(1'b1, 16'h0002, 16'h6666);
    req(1'b0, 16'h0004, 16'h0);
    chk("t4_no_write", bus.mem_write_en, 0);
    chk("t4_read", {bus.mem_read, bus.mem_access_addr}, {1'b1, 16'h0004});
    idle(1);
    chk("t4_rdata", bus.resp_rdata, 16'h0F0F);
    chk("t4_drain", {bus.mem_write_en, bus.mem_access_addr}, {1'b1, 16'h0001});
    idle(6);
    req(1'b1, 16'h0001, 16'h7777);
    req(1'b1, 16'h0005, 16'h8888);
    req(1'b1, 16'h0006, 16'h9999);
    req(1'b0, 16'h0007, 16'h0);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_resp_valid", bus.resp_valid, 0);
    chk("t5_mem_read", bus.mem_read, 0);
    chk("t5_sb_empty", bus.sb_empty, 1);
    chk("t5_ready_in_rst", bus.req_ready, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_ready_after", bus.req_ready, 1);
    idle(8);
    chk("t5_mem1_kept", mem[1], 16'h5555);
    chk("t5_mem5_kept", mem[5], 16'hAAAA);
    chk("t5_mem6_kept", mem[6], 16'hBBBB);
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = $urandom_range(0, 9) < 7;
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = 16'($urandom_range(0, 31));
      bus.req_wdata = 16'($urandom);
      @(posedge clk);
      #1;
    end
    idle(20);
    chk("t6_drained", bus.sb_empty, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
